// File: rtl/rr_mux_n_if.sv
// Handshake bundle for rr_mux_n: N input channels in, one registered beat out.
// RR_MUX_LAST_EN adds the in_last/out_last packet-boundary signals.
interface rr_mux_n_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;
`ifdef RR_MUX_LAST_EN
  logic [N-1:0]       in_last;
  logic               out_last;

  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_data, out_sel, out_valid, out_last);
  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_sel, out_valid, out_last);
`else
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_sel, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_sel, out_valid);
`endif
endinterface

// File: rtl/rr_mux_n.sv
// Round-robin N:1 mux with a single registered output stage (1 beat/cycle).
// RR_MUX_LAST_EN enables packet mode: a channel holds the grant until in_last.
module rr_mux_n #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  rr_mux_n_if.slave bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NU = N;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] gnt_inc;
  logic             found;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;

`ifdef RR_MUX_LAST_EN
  typedef enum logic {ST_ARB, ST_LOCK} state_t;
  state_t           state, state_next;
  logic [SEL_W-1:0] lock_ch;
  logic             last_q;
`endif

  assign load = !valid_q || bus.out_ready;
  assign xfer = load && found && !rst;

  // Scan from ptr upward with explicit wrap so non-power-of-two N never indexes >= N.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    gnt   = '0;
`ifdef RR_MUX_LAST_EN
    if (state == ST_LOCK) begin
      found = bus.in_valid[lock_ch];
      gnt   = lock_ch;
    end else
`endif
    for (int unsigned k = 0; k < NU; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NU) idx = idx - NU;
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        gnt   = SEL_W'(idx);
      end
    end
  end

  assign gnt_inc = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;

  always_comb begin
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NU; i++)
      bus.in_ready[i] = xfer && (gnt == SEL_W'(i));
  end

`ifdef RR_MUX_LAST_EN
  always_comb begin
    state_next = state;
    if (xfer) state_next = bus.in_last[gnt] ? ST_ARB : ST_LOCK;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
`ifdef RR_MUX_LAST_EN
      state   <= ST_ARB;
      lock_ch <= '0;
      last_q  <= 1'b0;
`endif
    end else if (load) begin
      if (found) begin
        data_q  <= bus.in_data[int'(gnt)*WIDTH +: WIDTH];
        sel_q   <= gnt;
        valid_q <= 1'b1;
`ifdef RR_MUX_LAST_EN
        state   <= state_next;
        lock_ch <= gnt;
        last_q  <= bus.in_last[gnt];
        if (bus.in_last[gnt]) ptr <= gnt_inc;
`else
        ptr     <= gnt_inc;
`endif
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;
`ifdef RR_MUX_LAST_EN
  assign bus.out_last  = last_q;
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed self-checking bench for rr_mux_n (N=4 and N=3 instances).
// Packet-mode steps are compiled in when RR_MUX_LAST_EN is defined.
module tb_rr_mux_n;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_mux_n_if #(.N(4), .WIDTH(8)) b ();
  rr_mux_n_if #(.N(3), .WIDTH(8)) b3 ();

  rr_mux_n #(.N(4), .WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(b));
  rr_mux_n #(.N(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    chk({tag, "_valid"}, b.out_valid, v);
    chk({tag, "_sel"},   b.out_sel,   s);
    chk({tag, "_data"},  b.out_data,  d);
  endtask

  initial begin
    // Reset with every channel requesting
    rst         = 1'b1;
    b.in_valid  = 4'hF;
    b.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b.out_ready = 1'b1;
    b3.in_valid  = '0;
    b3.in_data   = {8'hC2, 8'hC1, 8'hC0};
    b3.out_ready = 1'b1;
`ifdef RR_MUX_LAST_EN
    b.in_last  = 4'hF;
    b3.in_last = 3'h7;
`endif
    step();
    chk_out("rst1", 1'b0, 2'd0, 8'h00);
    chk("rst1_ready", b.in_ready, 4'h0);
    step();
    chk_out("rst2", 1'b0, 2'd0, 8'h00);
    chk("rst2_ready", b.in_ready, 4'h0);

    // Fairness: channel 0 first after reset, then strict rotation
    rst = 1'b0;
    #1;
    chk("fair_ready0", b.in_ready, 4'b0001);
    step(); chk_out("fair0", 1'b1, 2'd0, 8'hA0);
    chk("fair_ready1", b.in_ready, 4'b0010);
    step(); chk_out("fair1", 1'b1, 2'd1, 8'hA1);
    step(); chk_out("fair2", 1'b1, 2'd2, 8'hA2);
    step(); chk_out("fair3", 1'b1, 2'd3, 8'hA3);
    step(); chk_out("fair4", 1'b1, 2'd0, 8'hA0);

    // Reset mid-stream drops the held beat
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", b.in_ready, 4'h0);
    step(); chk_out("mid_rst", 1'b0, 2'd0, 8'h00);
    rst = 1'b0;

    // Pointer: ch2 alone twice, then 4'b1010
    b.in_valid = 4'b0100;
    step(); chk_out("ptr0", 1'b1, 2'd2, 8'hA2);
    step(); chk_out("ptr1", 1'b1, 2'd2, 8'hA2);
    b.in_valid = 4'b1010;
    step(); chk_out("ptr2", 1'b1, 2'd3, 8'hA3);
    step(); chk_out("ptr3", 1'b1, 2'd1, 8'hA1);

    // Idle: output invalidates, data/sel held
    b.in_valid = 4'b0000;
    step(); chk_out("idle", 1'b0, 2'd1, 8'hA1);

    // Backpressure: ptr=2, only ch0 valid -> captures 0x55
    b.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'h55};
    b.in_valid = 4'b0001;
    step(); chk_out("bp_cap", 1'b1, 2'd0, 8'h55);
    b.out_ready = 1'b0;
    b.in_valid  = 4'b0011;
    #1;
    chk("bp_ready", b.in_ready, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp_hold", 1'b1, 2'd0, 8'h55);
      chk("bp_hold_ready", b.in_ready, 4'h0);
    end
    b.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", b.in_ready, 4'b0010);
    step(); chk_out("bp_next", 1'b1, 2'd1, 8'hA1);
    b.in_valid = 4'b0000;

    // N=3 rotation; ptr wraps 2 -> 0
    b3.in_valid = 3'b111;
    step();
    chk("n3_sel0", b3.out_sel, 2'd0); chk("n3_data0", b3.out_data, 8'hC0); chk("n3_ptr0", dut3.ptr, 2'd1);
    step();
    chk("n3_sel1", b3.out_sel, 2'd1); chk("n3_data1", b3.out_data, 8'hC1); chk("n3_ptr1", dut3.ptr, 2'd2);
    step();
    chk("n3_sel2", b3.out_sel, 2'd2); chk("n3_data2", b3.out_data, 8'hC2); chk("n3_ptr2", dut3.ptr, 2'd0);
    step();
    chk("n3_sel3", b3.out_sel, 2'd0); chk("n3_ptr3", dut3.ptr, 2'd1);
    b3.in_valid = 3'b000;

`ifdef RR_MUX_LAST_EN
    // Packet: ch1 locks from ptr=0 so ch0 would otherwise win
    rst = 1'b1;
    step();
    rst = 1'b0;
    b.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b.in_last  = 4'b1101;
    b.in_valid = 4'b0010;
    step(); chk_out("pkt0", 1'b1, 2'd1, 8'hA1); chk("pkt0_last", b.out_last, 1'b0);
    b.in_valid = 4'b0111;
    #1;
    chk("pkt_lock_ready", b.in_ready, 4'b0010);
    step(); chk_out("pkt1", 1'b1, 2'd1, 8'hA1); chk("pkt1_last", b.out_last, 1'b0);
    b.in_last = 4'b1111;
    step(); chk_out("pkt2", 1'b1, 2'd1, 8'hA1); chk("pkt2_last", b.out_last, 1'b1);
    step(); chk_out("pkt3", 1'b1, 2'd2, 8'hA2);
    b.in_valid = 4'b0000;
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rr_mux_n.md
RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of input channels (legal range 2..64).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data bits per channel.
REQ-003 The block SHALL use derived width SEL_W = $clog2(N), minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, N bits: per-channel data valid.
REQ-008 The block SHALL have port in_ready, output, N bits: per-channel accept, combinational.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-010 The block SHALL have port out_sel, output, SEL_W bits: registered index of the channel that supplied out_data.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output register holds a beat.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-013 The block SHALL define load = !out_valid || out_ready; a new beat is captured only when load is 1.
REQ-014 The block SHALL grant the first channel with in_valid set, scanning upward from pointer ptr and wrapping from N-1 to 0.
REQ-015 The block SHALL drive in_ready[i] = load && (i is granted); at most one in_ready bit is high per cycle.
REQ-016 A transfer from channel g SHALL load out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N, with 1-cycle latency.
REQ-017 When load is 1 and no in_valid bit is set, the block SHALL clear out_valid and leave ptr, out_data and out_sel unchanged.
REQ-018 When out_valid && !out_ready, the block SHALL hold out_data, out_sel, out_valid and ptr, with all in_ready bits at 0.
REQ-019 Simultaneous drain and capture in one cycle SHALL be supported, giving a sustained throughput of 1 beat/cycle.
REQ-020 For non-power-of-two N, ptr and the grant scan SHALL never take values >= N.
REQ-021 in_valid bits that change while not granted SHALL not affect ptr; no input-side buffering is permitted.

Reset
REQ-022 While rst is high at a clock edge, the block SHALL set out_valid=0, out_data=0, out_sel=0, ptr=0 (and lock=0 when configured).
REQ-023 While rst is high, the block SHALL force all in_ready bits to 0; a beat held in the output register is discarded.
REQ-024 In the first cycle after rst falls, channel 0 SHALL have highest priority.

Configuration
REQ-025 Macro RR_MUX_LAST_EN SHALL select packet mode.
REQ-026 With RR_MUX_LAST_EN defined, the block SHALL add ports in_last (input, N) and out_last (output, 1, registered alongside out_data, reset 0).
REQ-027 With RR_MUX_LAST_EN defined, a transfer with in_last=0 SHALL set lock, record the channel, and not advance ptr; while locked, only the recorded channel is granted; a transfer with in_last=1 SHALL clear lock and set ptr <= channel+1.
REQ-028 Without RR_MUX_LAST_EN, in_last, out_last and the lock logic SHALL be absent, and every beat is arbitrated independently.

Verification (N=4, WIDTH=8 unless stated)
REQ-029 Reset: hold rst=1 for 2 cycles with in_valid=4'hF -> out_valid=0, out_data=0, out_sel=0, in_ready=0; assert rst mid-stream -> output beat dropped next edge.
REQ-030 Fairness: in_valid=4'hF continuously, in_data ch i = 8'hA0+i, out_ready=1 -> out_sel 0,1,2,3,0 and out_data A0,A1,A2,A3,A0 on consecutive cycles.
REQ-031 Pointer: only ch2 valid for 2 beats, then in_valid=4'b1010 -> out_sel 2,2,3,1.
REQ-032 Backpressure: capture 8'h55, out_ready=0 for 3 cycles -> out_data=8'h55 held, in_ready=0; out_ready=1 -> next beat on following cycle with no gap.
REQ-033 N=3: in_valid=3'b111 -> out_sel 0,1,2,0; internal ptr never reaches 3.
REQ-034 With RR_MUX_LAST_EN: ch1 sends 3 beats (last on the third) while ch0 and ch2 are valid -> out_sel 1,1,1,2 and out_last 0,0,1,x.
